// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parameterised single-clock FIFO with a valid/ready producer
// side and a valid/yumi consumer side.
//
// Ports:
//   clk, reset_n     clock and synchronous active-low reset
//   flush_i          synchronous clear of pointers, count and err_o
//   valid_i, data_i  producer side. A push happens when valid_i & rdy.
//   rdy              FIFO has room (count != DEPTH)
//   valid_o, data_o  consumer side. data_o is the head entry.
//   yumi             consumer takes the head. Legal only while valid_o = 1.
//   count_o          occupancy, 0..DEPTH
//   almost_full_o    count_o >= AF_THRESH
//   almost_empty_o   count_o <= AE_THRESH
//   err_o            sticky flag: yumi was seen while the FIFO was empty
//
// Every output is decoded from registered state. No input reaches an output
// combinationally.
module fifo_sync_param #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 6,
  parameter  int AF_THRESH = DEPTH - 1,
  parameter  int AE_THRESH = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             rdy,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             yumi,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             err;
  logic             push, pop, clr;

  // The pointers wrap explicitly at DEPTH-1. With a non-power-of-two DEPTH,
  // natural binary rollover would index entries that do not exist.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rdy     = (count != DEPTH_C);
  assign valid_o = (count != '0);
  assign push    = valid_i & rdy;
  assign pop     = yumi & valid_o;
  // Reset and flush do the same thing. Either one overrides any push or pop
  // in the same cycle.
  assign clr     = !reset_n || flush_i;

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (yumi && !valid_o) err <= 1'b1;
    end
  end

  // Storage is not reset. Stale entries are never exposed because valid_o
  // follows count.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr] <= data_i;
  end

  assign data_o         = mem[rptr];
  assign count_o        = count;
  assign almost_full_o  = (count >= AF_C);
  assign almost_empty_o = (count <= AE_C);
  assign err_o          = err;

  // Pointer distance modulo DEPTH. The value is ambiguous when wptr == rptr:
  // that case means either empty or full.
  logic [CW-1:0] ptr_dist;
  always_comb begin
    ptr_dist = '0;
    if (wptr >= rptr) ptr_dist = CW'(wptr - rptr);
    else              ptr_dist = CW'(DEPTH - int'(rptr) + int'(wptr));
  end

  a_count_ptr: assert property (@(posedge clk) disable iff (!reset_n)
    (count == ptr_dist) || ((wptr == rptr) && (count == DEPTH_C)));

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed, table-driven check of fifo_sync_param with
// WIDTH=8 and DEPTH=6, plus hand-written wrap, reset and flush sequences.
module tb_fifo_sync_param;
  localparam int W  = 8;
  localparam int D  = 6;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          rdy, valid_o, yumi = 1'b0;
  logic [W-1:0]  data_o;
  logic [CW-1:0] count_o;
  logic          almost_full_o, almost_empty_o, err_o;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(D - 1), .AE_THRESH(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i),
    .data_i(data_i), .rdy(rdy), .valid_o(valid_o), .data_o(data_o),
    .yumi(yumi), .count_o(count_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         vi;
    logic [W-1:0] d;
    logic         y;
    logic         fl;
    logic         e_rdy;
    logic         e_vo;
    logic [W-1:0] e_d;
    logic         chk_d;
    int           e_cnt;
    logic         e_af;
    logic         e_ae;
    logic         e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive the inputs on the falling edge. Sample the outputs 1 time unit
  // after the following rising edge.
  task automatic cyc(input logic vi, input logic [W-1:0] d, input logic y,
                     input logic fl, input logic rn);
    @(negedge clk);
    valid_i = vi; data_i = d; yumi = y; flush_i = fl; reset_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string t, input logic rd, input logic vo,
                         input logic [W-1:0] d, input logic cd, input int cnt,
                         input logic af, input logic ae, input logic er);
    chk({t, "_rdy"}, 32'(rdy), 32'(rd));
    chk({t, "_valid"}, 32'(valid_o), 32'(vo));
    if (cd) chk({t, "_data"}, 32'(data_o), 32'(d));
    chk({t, "_count"}, 32'(count_o), 32'(cnt));
    chk({t, "_af"}, 32'(almost_full_o), 32'(af));
    chk({t, "_ae"}, 32'(almost_empty_o), 32'(ae));
    chk({t, "_err"}, 32'(err_o), 32'(er));
  endtask

  task automatic add(input logic vi, input logic [W-1:0] d, input logic y,
                     input logic fl, input logic rd, input logic vo,
                     input logic [W-1:0] ed, input logic cd, input int cnt,
                     input logic af, input logic ae, input logic er);
    vec_t v;
    v.vi = vi; v.d = d; v.y = y; v.fl = fl; v.e_rdy = rd; v.e_vo = vo;
    v.e_d = ed; v.chk_d = cd; v.e_cnt = cnt; v.e_af = af; v.e_ae = ae; v.e_err = er;
    vecs.push_back(v);
  endtask

  initial begin
    // Columns: vi d y fl | rdy vo data chk_d cnt af ae err
    // Fill 0x11..0x16. The 7th push (0x77) is refused.
    add(1, 8'h11, 0, 0,  1, 1, 8'h11, 1, 1, 0, 1, 0);
    add(1, 8'h12, 0, 0,  1, 1, 8'h11, 1, 2, 0, 0, 0);
    add(1, 8'h13, 0, 0,  1, 1, 8'h11, 1, 3, 0, 0, 0);
    add(1, 8'h14, 0, 0,  1, 1, 8'h11, 1, 4, 0, 0, 0);
    add(1, 8'h15, 0, 0,  1, 1, 8'h11, 1, 5, 1, 0, 0);
    add(1, 8'h16, 0, 0,  0, 1, 8'h11, 1, 6, 1, 0, 0);
    add(1, 8'h77, 0, 0,  0, 1, 8'h11, 1, 6, 1, 0, 0);
    // Drain the FIFO in order.
    add(0, 8'h00, 1, 0,  1, 1, 8'h12, 1, 5, 1, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'h13, 1, 4, 0, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'h14, 1, 3, 0, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'h15, 1, 2, 0, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'h16, 1, 1, 0, 1, 0);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 0, 0, 1, 0);
    // Underflow sets err_o. The flag holds while idle and clears on flush.
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 0, 0, 1, 1);
    add(0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 1, 1);
    add(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0, 0, 1, 0);
    // Push and pop in the same cycle at count=3.
    add(1, 8'hA0, 0, 0,  1, 1, 8'hA0, 1, 1, 0, 1, 0);
    add(1, 8'hA1, 0, 0,  1, 1, 8'hA0, 1, 2, 0, 0, 0);
    add(1, 8'hA2, 0, 0,  1, 1, 8'hA0, 1, 3, 0, 0, 0);
    add(1, 8'hA3, 1, 0,  1, 1, 8'hA1, 1, 3, 0, 0, 0);
    add(1, 8'hA4, 1, 0,  1, 1, 8'hA2, 1, 3, 0, 0, 0);
    add(1, 8'hA5, 0, 0,  1, 1, 8'hA2, 1, 4, 0, 0, 0);
    add(1, 8'hA6, 0, 0,  1, 1, 8'hA2, 1, 5, 1, 0, 0);
    add(1, 8'hA7, 0, 0,  0, 1, 8'hA2, 1, 6, 1, 0, 0);
    // At full, pushing 0xAA with a pop: the pop happens and 0xAA is dropped.
    add(1, 8'hAA, 1, 0,  1, 1, 8'hA3, 1, 5, 1, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'hA4, 1, 4, 0, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'hA5, 1, 3, 0, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'hA6, 1, 2, 0, 0, 0);
    add(0, 8'h00, 1, 0,  1, 1, 8'hA7, 1, 1, 0, 1, 0);
    add(0, 8'h00, 1, 0,  1, 0, 8'h00, 0, 0, 0, 1, 0);

    // Hold reset for 2 cycles with valid_i and yumi high.
    cyc(1, 8'h55, 1, 0, 0);
    cyc(1, 8'h55, 1, 0, 0);
    chk_all("reset", 1, 0, 8'h00, 0, 0, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 1);
    chk_all("post_reset", 1, 0, 8'h00, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].vi, vecs[i].d, vecs[i].y, vecs[i].fl, 1'b1);
      chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vo, vecs[i].e_d,
              vecs[i].chk_d, vecs[i].e_cnt, vecs[i].e_af, vecs[i].e_ae, vecs[i].e_err);
    end

    // Wrap: alternate a push of k and a pop, 20 times. The pointers cross the
    // DEPTH-1 -> 0 boundary several times.
    for (int k = 0; k < 20; k++) begin
      cyc(1, 8'(k), 0, 0, 1);
      chk($sformatf("wrap%0d_data", k), 32'(data_o), 32'(k));
      chk($sformatf("wrap%0d_count", k), 32'(count_o), 32'd1);
      cyc(0, 8'h00, 1, 0, 1);
      chk($sformatf("wrap%0d_empty", k), 32'(valid_o), 32'd0);
    end

    // Flush mid-stream. The push made in the flush cycle is discarded.
    for (int k = 1; k <= 4; k++) cyc(1, 8'(k), 0, 0, 1);
    chk("pre_flush_count", 32'(count_o), 32'd4);
    cyc(1, 8'h05, 0, 1, 1);
    chk_all("flush", 1, 0, 8'h00, 0, 0, 0, 1, 0);
    cyc(1, 8'h09, 0, 0, 1);
    chk_all("after_flush", 1, 1, 8'h09, 1, 1, 0, 1, 0);

    // Reset in the same cycle as push and flush: reset wins.
    cyc(1, 8'h0A, 0, 0, 1);
    cyc(1, 8'h0B, 1, 1, 0);
    chk_all("mid_reset", 1, 0, 8'h00, 0, 0, 0, 1, 0);
    cyc(1, 8'h0C, 0, 0, 1);
    chk_all("after_reset", 1, 1, 8'h0C, 1, 1, 0, 1, 0);
    cyc(0, 8'h00, 1, 0, 1);
    chk_all("final_empty", 1, 0, 8'h00, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
